// File: rtl/block_digit_pkg.sv
// block_digit_pkg: shared definitions for the block-digit decoder and renderer.
//   - default box geometry (W/H/THICK)
//   - segment bit positions inside a {a,b,c,d,e,f,g} mask
//   - decoder state enum
//   - digit-to-mask table and the reverse lookup
//   - per-segment pixel areas used as decode thresholds
package block_digit_pkg;

  localparam int unsigned W_DEF     = 50;
  localparam int unsigned H_DEF     = 70;
  localparam int unsigned THICK_DEF = 8;

  localparam int unsigned NUM_SEG = 7;

  // Bit positions in a {a,b,c,d,e,f,g} mask (a is the MSB).
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  typedef logic [NUM_SEG-1:0] seg_mask_t;

  // Horizontal strokes (a, d, g) share one area; the verticals share the other.
  localparam seg_mask_t HORIZ_SEGS = 7'b1001001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECODE = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam seg_mask_t DIGIT_MASK [10] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } decode_t;

  function automatic int unsigned area_horiz(int unsigned w, int unsigned t);
    return (w - 2 * t) * t;
  endfunction

  function automatic int unsigned area_vert(int unsigned h, int unsigned t);
    return t * (h / 2 - t / 2 - t);
  endfunction

  // Any mask outside the table (including all-dark) decodes as an error.
  function automatic decode_t mask_to_digit(seg_mask_t m);
    decode_t r;
    r.err   = 1'b1;
    r.digit = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (m == DIGIT_MASK[i]) begin
        r.err   = 1'b0;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/block_digit_seg_classify.sv
// block_digit_seg_classify: combinational map from box-relative pixel
// coordinates to the segment that pixel belongs to.
//   rel_x, rel_y : box-relative coordinates (wrapped unsigned)
//   seg_hit      : one-hot {a,b,c,d,e,f,g}, zero for gaps and outside the box
//   in_box       : pixel lies inside the W x H box
// All bounds are half-open: [lo, hi).
module block_digit_seg_classify
  import block_digit_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned H     = H_DEF,
  parameter int unsigned THICK = THICK_DEF
) (
  input  logic [9:0] rel_x,
  input  logic [9:0] rel_y,
  output seg_mask_t  seg_hit,
  output logic       in_box
);

  localparam logic [9:0] X_L  = 10'(THICK);
  localparam logic [9:0] X_R  = 10'(W - THICK);
  localparam logic [9:0] X_E  = 10'(W);
  localparam logic [9:0] Y_T  = 10'(THICK);
  localparam logic [9:0] Y_G0 = 10'(H / 2 - THICK / 2);
  localparam logic [9:0] Y_G1 = 10'(H / 2 - THICK / 2 + THICK);
  localparam logic [9:0] Y_D  = 10'(H - THICK);
  localparam logic [9:0] Y_E  = 10'(H);

  logic col_l, col_m, col_r;
  logic row_a, row_up, row_g, row_lo, row_d;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    seg_hit = '0;
    in_box  = (rel_x < X_E) && (rel_y < Y_E);

    col_l  = (rel_x < X_L);
    col_m  = (rel_x >= X_L) && (rel_x < X_R);
    col_r  = (rel_x >= X_R) && (rel_x < X_E);
    row_a  = (rel_y < Y_T);
    row_up = (rel_y >= Y_T)  && (rel_y < Y_G0);
    row_g  = (rel_y >= Y_G0) && (rel_y < Y_G1);
    row_lo = (rel_y >= Y_G1) && (rel_y < Y_D);
    row_d  = (rel_y >= Y_D)  && (rel_y < Y_E);

    seg_hit[SEG_A] = col_m && row_a;
    seg_hit[SEG_B] = col_r && row_up;
    seg_hit[SEG_C] = col_r && row_lo;
    seg_hit[SEG_D] = col_m && row_d;
    seg_hit[SEG_E] = col_l && row_lo;
    seg_hit[SEG_F] = col_l && row_up;
    seg_hit[SEG_G] = col_m && row_g;
  end

endmodule

// File: rtl/block_digit_decoder.sv
// block_digit_decoder: counts lit pixels per segment of a block digit over one
// frame and decodes the resulting 7-segment mask to a digit.
//   clk, reset            : clock, synchronous active-high reset
//   frame_start/frame_end : single-cycle frame delimiters
//   pix_valid, px, py     : pixel strobe and coordinates
//   pix_on                : pixel lit
//   base_x, base_y        : box origin, captured on frame_start
//   digit, seg_mask       : last decoded digit and mask {a..g}
//   digit_valid           : one-cycle strobe, 2 cycles after frame_end
//   digit_err             : last mask was not a legal digit (held to next strobe)
// Optional: define BLOCK_DIGIT_DECODER_GAP_CHECK_EN to count lit pixels in the
// gaps between segments and flag the frame as an error when there are too many.
module block_digit_decoder
  import block_digit_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned H     = H_DEF,
  parameter int unsigned THICK = THICK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       pix_valid,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       pix_on,
  input  logic [9:0] base_x,
  input  logic [9:0] base_y,
  output logic [3:0] digit,
  output seg_mask_t  seg_mask,
  output logic       digit_valid,
  output logic       digit_err
);

  localparam int unsigned AREA_H = area_horiz(W, THICK);
  localparam int unsigned AREA_V = area_vert(H, THICK);

  state_e     state_q, state_d;
  logic [9:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic [8:0] cnt_q [NUM_SEG];
  logic [8:0] cnt_d [NUM_SEG];
  logic [3:0] digit_q, digit_d;
  seg_mask_t  seg_mask_q, seg_mask_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  seg_mask_t  seg_hit;
  logic       in_box;
  logic       pix_lit;
  seg_mask_t  seg_on;
  decode_t    dec;

`ifdef BLOCK_DIGIT_DECODER_GAP_CHECK_EN
  localparam logic [8:0] GAP_LIMIT = 9'(THICK * THICK);
  logic [8:0] gap_cnt_q, gap_cnt_d;
`endif

  block_digit_seg_classify #(.W(W), .H(H), .THICK(THICK)) u_classify (
    .rel_x   (px - base_x_q),
    .rel_y   (py - base_y_q),
    .seg_hit (seg_hit),
    .in_box  (in_box)
  );

  // A pixel in the frame_start cycle belongs to no frame and is dropped.
  assign pix_lit = pix_valid && pix_on && !frame_start && in_box;

  // Threshold: a segment is on when at least half its area is lit.
  always_comb begin
    seg_on = '0;
    for (int s = 0; s < NUM_SEG; s++) begin
      seg_on[s] = (32'({cnt_q[s], 1'b0}) >= (HORIZ_SEGS[s] ? AREA_H : AREA_V));
    end
    dec = mask_to_digit(seg_on);
`ifdef BLOCK_DIGIT_DECODER_GAP_CHECK_EN
    if (gap_cnt_q > GAP_LIMIT) begin
      dec.err   = 1'b1;
      dec.digit = 4'hF;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    seg_mask_d = seg_mask_q;
    valid_d    = 1'b0;
    err_d      = err_q;
`ifdef BLOCK_DIGIT_DECODER_GAP_CHECK_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    unique case (state_q)
      IDLE, ACCUM: begin
        if (frame_start) begin
          // Also covers a restart from ACCUM; frame_end in the same cycle loses.
          cnt_d    = '{default: '0};
          base_x_d = base_x;
          base_y_d = base_y;
          state_d  = ACCUM;
`ifdef BLOCK_DIGIT_DECODER_GAP_CHECK_EN
          gap_cnt_d = '0;
`endif
        end else if (state_q == ACCUM) begin
          for (int s = 0; s < NUM_SEG; s++) begin
            if (pix_lit && seg_hit[s] && (cnt_q[s] != 9'h1FF)) begin
              cnt_d[s] = cnt_q[s] + 9'd1;
            end
          end
`ifdef BLOCK_DIGIT_DECODER_GAP_CHECK_EN
          if (pix_lit && (seg_hit == '0) && (gap_cnt_q != 9'h1FF)) begin
            gap_cnt_d = gap_cnt_q + 9'd1;
          end
`endif
          if (frame_end) state_d = DECODE;
        end
      end
      // Outputs are registered on leaving DECODE, so they appear in REPORT.
      DECODE: begin
        seg_mask_d = seg_on;
        digit_d    = dec.digit;
        err_d      = dec.err;
        valid_d    = 1'b1;
        state_d    = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_x_q   <= '0;
      base_y_q   <= '0;
      cnt_q      <= '{default: '0};
      digit_q    <= 4'hF;
      seg_mask_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef BLOCK_DIGIT_DECODER_GAP_CHECK_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      seg_mask_q <= seg_mask_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef BLOCK_DIGIT_DECODER_GAP_CHECK_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign digit       = digit_q;
  assign seg_mask    = seg_mask_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;

endmodule

// File: doc/block_digit_decoder.md
BLOCK_DIGIT_DECODER -- requirements
Module: block_digit_decoder

Interface
REQ-001 The block SHALL have parameter W, default 50, which is the digit box width in pixels.
REQ-002 The block SHALL have parameter H, default 70, which is the digit box height in pixels.
REQ-003 The block SHALL have parameter THICK, default 8, which is the segment stroke thickness in pixels.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have ports frame_start and frame_end, input, 1 bit each, single-cycle frame delimiters.
REQ-007 The block SHALL have port pix_valid, input, 1 bit, which qualifies px, py and pix_on.
REQ-008 The block SHALL have ports px and py, input, 10 bits each, the pixel coordinates.
REQ-009 The block SHALL have port pix_on, input, 1 bit, the pixel-lit flag.
REQ-010 The block SHALL have ports base_x and base_y, input, 10 bits each, the box origin, sampled on frame_start.
REQ-011 The block SHALL have port digit, output, 4 bits, the last decoded value.
REQ-012 The block SHALL have port seg_mask, output, 7 bits, ordered {a,b,c,d,e,f,g}, the last decoded segment mask.
REQ-013 The block SHALL have port digit_valid, output, 1 bit, a one-cycle result strobe.
REQ-014 The block SHALL have port digit_err, output, 1 bit, high when the mask is not a legal digit 0-9; it is held until the next strobe.

Function
REQ-015 Segment regions SHALL be the block-digit geometry: a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle; edges are W/H/THICK-derived with half-open bounds, and coordinates are box-relative (px-base_x, py-base_y; unsigned wrap puts pixels left of or above the box out of bounds).
REQ-016 The block SHALL implement states IDLE, ACCUM, DECODE and REPORT.
REQ-017 In IDLE, frame_start SHALL clear all seven counters, latch base_x/base_y, and move to ACCUM; frame_end in IDLE SHALL be ignored.
REQ-018 In ACCUM, each cycle with pix_valid && pix_on inside a segment region SHALL increment that segment's 9-bit counter, saturating at 511.
REQ-019 A pixel arriving in the frame_start cycle SHALL NOT be counted; a pixel arriving in the frame_end cycle SHALL be counted.
REQ-020 In ACCUM, frame_start SHALL take priority over a simultaneous frame_end: the frame is discarded, counters are cleared, base is relatched, and the state remains ACCUM.
REQ-021 In ACCUM, frame_end SHALL move the state to DECODE.
REQ-022 In DECODE, mask bit s SHALL be set iff 2*count[s] >= area[s], where area(a,d,g)=(W-2*THICK)*THICK and area(b,c,e,f)=THICK*(H/2-THICK/2-THICK), i.e. 272/184 at defaults.
REQ-023 In REPORT, seg_mask and digit SHALL update and digit_valid SHALL pulse for exactly one cycle, then the state returns to IDLE; digit_valid is therefore high exactly 2 cycles after the frame_end cycle.
REQ-024 A mask matching a standard block-digit pattern SHALL give digit 0-9 with digit_err=0; any other mask, including all-zero, SHALL give digit=4'hF and digit_err=1.
REQ-025 frame_start arriving during DECODE or REPORT SHALL be ignored, and the in-flight result SHALL complete.

Reset
REQ-026 On reset, the state SHALL be IDLE, counters 0, digit 4'hF, seg_mask 0, digit_valid 0, digit_err 0, and latched base 0.
REQ-027 Reset asserted mid-ACCUM SHALL discard the frame, and no digit_valid SHALL be produced for it.

Configuration
REQ-028 With BLOCK_DIGIT_DECODER_GAP_CHECK_EN defined, an eighth 9-bit saturating counter SHALL count lit pixels inside the box but outside all segments.
REQ-029 With BLOCK_DIGIT_DECODER_GAP_CHECK_EN defined, a gap count > THICK*THICK (64) SHALL force digit_err=1 and digit=4'hF regardless of the mask.
REQ-030 With BLOCK_DIGIT_DECODER_GAP_CHECK_EN undefined, gap pixels SHALL be ignored and no gap counter SHALL exist.

Structure
REQ-031 Package block_digit_pkg SHALL hold the W/H/THICK defaults, segment index constants A..G, the state enum, the 10-entry digit-to-mask table shared with the renderer, and the area functions.
REQ-032 A combinational sub-module block_digit_seg_classify SHALL map (relative x, relative y) to a 7-bit one-hot segment hit plus an in_box flag; the decoder SHALL instantiate it once.

Verification
REQ-033 The bench SHALL cover: base (100,50), full raster of digit 8 lit per geometry, then frame_end -> digit_valid 2 cycles later, digit=8, seg_mask=7'b1111111, err=0.
REQ-034 The bench SHALL cover: digit 1 raster -> seg_mask=7'b0110000, digit=1; then an all-dark frame -> digit=4'hF, err=1.
REQ-035 The bench SHALL cover the threshold: segment a at 135 lit pixels -> bit clear; segment a at 136 lit pixels -> bit set; all other segments drawn as digit 7.
REQ-036 The bench SHALL cover: frame_start mid-ACCUM after a partial digit 8, then a full digit 2 -> single strobe with digit=2 and no strobe for the aborted frame.
REQ-037 The bench SHALL cover: reset at ACCUM cycle 500 -> outputs at reset values, and a later frame_end produces no strobe.
REQ-038 The bench SHALL cover, with BLOCK_DIGIT_DECODER_GAP_CHECK_EN defined: digit 0 plus 65 lit corner pixels -> err=1, digit=4'hF; the same stimulus with the macro undefined -> digit=0.
